// File: rtl/sm_regdump_tx.sv
// Register-file dump engine: walks FIRST..LAST on the CPU debug port and streams
// each captured word as UART 8N1 bytes, framed by a 0xA5 header and 0x5A trailer.
module sm_regdump_tx #(
    parameter int BAUD_DIV = 434,
    parameter int SETTLE   = 3,
    parameter int FIRST    = 0,
    parameter int LAST     = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [4:0]  FIRST_ADDR  = 5'(FIRST);
    localparam logic [4:0]  LAST_ADDR   = 5'(LAST);
    localparam logic [7:0]  HDR_BYTE    = 8'hA5;
    localparam logic [7:0]  TRL_BYTE    = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_TRL     = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Byte idx of one register record: address first, then the word MSB first.
    function automatic logic [7:0] record_byte(input logic [31:0] word,
                                               input logic [4:0]  addr,
                                               input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {3'b000, addr};
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r;
    logic [15:0] baud_cnt_r;
    logic [3:0]  bit_idx_r;
    logic [2:0]  byte_idx_r;
    logic [7:0]  settle_cnt_r;
    logic [8:0]  frame_r;
    logic [31:0] hold_r;
    logic [4:0]  addr_r;
    logic        tx_r;
    logic        busy_r;
    logic        done_r;

    logic        serial_s;
    logic        bit_end_s;
    logic        byte_end_s;
    logic [2:0]  next_byte_idx_s;

    assign serial_s        = (state_r == ST_HDR) || (state_r == ST_SEND) || (state_r == ST_TRL);
    assign bit_end_s       = (baud_cnt_r == BAUD_LAST);
    assign byte_end_s      = serial_s && bit_end_s && (bit_idx_r == 4'd9);
    assign next_byte_idx_s = byte_idx_r + 3'd1;

    // Dump sequencer and bit serialiser; frame_r holds the bits still to go out after tx_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            baud_cnt_r   <= 16'd0;
            bit_idx_r    <= 4'd0;
            byte_idx_r   <= 3'd0;
            settle_cnt_r <= 8'd0;
            frame_r      <= 9'h1FF;
            hold_r       <= 32'd0;
            addr_r       <= FIRST_ADDR;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (serial_s && !byte_end_s) begin
                if (bit_end_s) begin
                    baud_cnt_r <= 16'd0;
                    bit_idx_r  <= bit_idx_r + 4'd1;
                    tx_r       <= frame_r[0];
                    frame_r    <= {1'b1, frame_r[8:1]};
                end else begin
                    baud_cnt_r <= baud_cnt_r + 16'd1;
                end
            end else begin
                baud_cnt_r <= 16'd0;
                bit_idx_r  <= 4'd0;
            end

            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_HDR;
                        busy_r  <= 1'b1;
                        frame_r <= {1'b1, HDR_BYTE};
                        tx_r    <= 1'b0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (byte_end_s) begin
                        state_r      <= ST_SETTLE;
                        addr_r       <= FIRST_ADDR;
                        settle_cnt_r <= 8'd0;
                        tx_r         <= 1'b1;
                    end else begin
                        state_r <= ST_HDR;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r      <= ST_CAPTURE;
                        settle_cnt_r <= 8'd0;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    hold_r     <= regData;
                    byte_idx_r <= 3'd0;
                    frame_r    <= {1'b1, 3'b000, addr_r};
                    tx_r       <= 1'b0;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    if (byte_end_s) begin
                        if (byte_idx_r == 3'd4) begin
                            byte_idx_r <= 3'd0;
                            // LAST is checked before incrementing, so the address never wraps.
                            if (addr_r == LAST_ADDR) begin
                                state_r <= ST_TRL;
                                frame_r <= {1'b1, TRL_BYTE};
                                tx_r    <= 1'b0;
                            end else begin
                                state_r      <= ST_SETTLE;
                                addr_r       <= addr_r + 5'd1;
                                settle_cnt_r <= 8'd0;
                                tx_r         <= 1'b1;
                            end
                        end else begin
                            byte_idx_r <= next_byte_idx_s;
                            frame_r    <= {1'b1, record_byte(hold_r, addr_r, next_byte_idx_s)};
                            tx_r       <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_TRL: begin
                    if (byte_end_s) begin
                        state_r <= ST_DONE;
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_TRL;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign regAddr = addr_r;
    assign tx      = tx_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_sm_regdump_tx.sv
// Directed bench for sm_regdump_tx: a 32-register dump instance and a single-register
// instance, each with a UART byte decoder on tx.
module tb_sm_regdump_tx;

    localparam int B        = 4;
    localparam int S        = 2;
    localparam int FRAME1   = 70 * B + S + 1;
    localparam int FULL_CYC = 10 * B + 32 * (S + 1 + 50 * B) + 10 * B;
    localparam int LIMIT    = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a;
    logic [31:0] data_b = 32'd0;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sm_regdump_tx #(.BAUD_DIV(B), .SETTLE(S), .FIRST(0), .LAST(31)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .regAddr(addr_a), .regData(data_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    sm_regdump_tx #(.BAUD_DIV(B), .SETTLE(S), .FIRST(5), .LAST(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .regAddr(addr_b), .regData(data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // Register model with one-cycle pipeline and one cycle of 0xFFFFFFFF after each address change.
    logic [4:0] prev_a;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_a <= 5'd0;
            data_a <= 32'hDEAD0000;
        end else begin
            prev_a <= addr_a;
            data_a <= (addr_a != prev_a) ? 32'hFFFFFFFF : (32'hDEAD0000 | {27'd0, addr_a});
        end
    end

    // UART decoders, sampling mid-bit on the falling clock edge.
    logic [1:0]  txv;
    assign txv = {tx_b, tx_a};
    logic        mon_act [2];
    int          mon_cnt [2];
    logic [7:0]  mon_sh [2];
    byte unsigned q_a[$];
    byte unsigned q_b[$];
    int          ferr = 0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mon_act[i] <= 1'b0;
                mon_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!mon_act[i]) begin
                    if (txv[i] == 1'b0) begin
                        mon_act[i] <= 1'b1;
                        mon_cnt[i] <= 1;
                    end
                end else begin
                    mon_cnt[i] <= mon_cnt[i] + 1;
                    if (mon_cnt[i] == B / 2 && txv[i] != 1'b0) mon_act[i] <= 1'b0;
                    if (mon_cnt[i] >= B + B / 2 && mon_cnt[i] <= 8 * B + B / 2 && (mon_cnt[i] % B) == B / 2)
                        mon_sh[i] <= {txv[i], mon_sh[i][7:1]};
                    if (mon_cnt[i] == 9 * B + B / 2) begin
                        mon_act[i] <= 1'b0;
                        if (txv[i] != 1'b1) ferr <= ferr + 1;
                        else if (i == 0) q_a.push_back(mon_sh[0]);
                        else q_b.push_back(mon_sh[1]);
                    end
                end
            end
        end
    end

    function automatic int q_diff(input byte unsigned got[$], input byte unsigned want[$]);
        int d = 0;
        for (int i = 0; i < want.size() && i < got.size(); i++)
            if (got[i] != want[i]) d++;
        d += (got.size() > want.size()) ? got.size() - want.size() : want.size() - got.size();
        return d;
    endfunction

    task automatic kick_a();
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
    endtask

    task automatic kick_b();
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (done_a !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_done_b(output int n);
        n = 0;
        while (done_b !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++; if (tx_a !== 1'b1) $display("FAIL reset_tx_a: got %b want 1", tx_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a: got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (done_a !== 1'b0) $display("FAIL reset_done_a: got %b want 0", done_a); else pass_cnt++;
        total_cnt++; if (addr_a !== 5'd0) $display("FAIL reset_addr_a: got %0d want 0", addr_a); else pass_cnt++;
        total_cnt++; if (addr_b !== 5'd5) $display("FAIL reset_addr_b: got %0d want 5", addr_b); else pass_cnt++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total_cnt++; if (tx_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL idle_b: got tx=%b busy=%b want tx=1 busy=0", tx_b, busy_b); else pass_cnt++;
    endtask

    task automatic test_full_dump();
        byte unsigned exp[$];
        int n, ff;
        exp.push_back(8'hA5);
        for (int a = 0; a < 32; a++) begin
            exp.push_back(8'(a)); exp.push_back(8'hDE); exp.push_back(8'hAD);
            exp.push_back(8'h00); exp.push_back(8'(a));
        end
        exp.push_back(8'h5A);
        q_a.delete();
        kick_a();
        total_cnt++; if (busy_a !== 1'b1 || tx_a !== 1'b0) $display("FAIL full_start: got busy=%b tx=%b want busy=1 tx=0", busy_a, tx_a); else pass_cnt++;
        wait_done_a(n);
        total_cnt++; if (n != FULL_CYC) $display("FAIL full_latency: got %0d want %0d", n, FULL_CYC); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL full_busy_fall: got %b want 0", busy_a); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (done_a !== 1'b0) $display("FAIL full_done_pulse: got %b want 0", done_a); else pass_cnt++;
        total_cnt++; if (addr_a !== 5'd31) $display("FAIL full_addr_hold: got %0d want 31", addr_a); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (q_diff(q_a, exp) != 0) $display("FAIL full_bytes: got %0d bytes with %0d differences want 162 matching", q_a.size(), q_diff(q_a, exp)); else pass_cnt++;
        ff = 0;
        foreach (q_a[i]) if (q_a[i] == 8'hFF) ff++;
        total_cnt++; if (ff != 0) $display("FAIL settle_no_ff: got %0d 0xFF bytes want 0", ff); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int n, drops;
        q_a.delete();
        kick_a();
        n = 0; drops = 0;
        while (done_a !== 1'b1 && n < LIMIT) begin
            @(negedge clk); start_a = (n % 100 == 99);
            @(posedge clk); #1; n++;
            if (done_a !== 1'b1 && busy_a !== 1'b1) drops++;
        end
        start_a = 1'b0;
        total_cnt++; if (n != FULL_CYC) $display("FAIL ignore_latency: got %0d want %0d", n, FULL_CYC); else pass_cnt++;
        total_cnt++; if (drops != 0) $display("FAIL ignore_busy: got %0d low cycles want 0", drops); else pass_cnt++;
        repeat (30) @(negedge clk);
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL ignore_no_queue: got busy=%b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (q_a.size() != 162) $display("FAIL ignore_one_frame: got %0d bytes want 162", q_a.size()); else pass_cnt++;
    endtask

    task automatic test_single();
        byte unsigned exp[$] = '{8'hA5, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h5A};
        int n;
        q_b.delete();
        data_b = 32'h12345678;
        kick_b();
        total_cnt++; if (busy_b !== 1'b1 || tx_b !== 1'b0) $display("FAIL single_start: got busy=%b tx=%b want busy=1 tx=0", busy_b, tx_b); else pass_cnt++;
        wait_done_b(n);
        total_cnt++; if (n != FRAME1) $display("FAIL single_len: got %0d want %0d", n, FRAME1); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (q_diff(q_b, exp) != 0) $display("FAIL single_bytes: got %0d bytes with %0d differences want 7 matching", q_b.size(), q_diff(q_b, exp)); else pass_cnt++;
        total_cnt++; if (ferr != 0) $display("FAIL stop_bits: got %0d framing errors want 0", ferr); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        byte unsigned exp[$] = '{8'hA5, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h5A,
                                 8'hA5, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h5A};
        int n1, n2, m;
        q_b.delete();
        data_b = 32'h12345678;
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1;
        wait_done_b(n1);
        total_cnt++; if (n1 != FRAME1) $display("FAIL b2b_len1: got %0d want %0d", n1, FRAME1); else pass_cnt++;
        m = 0;
        while (busy_b !== 1'b1 && m < 10) begin @(posedge clk); #1; m++; end
        total_cnt++; if (m != 2) $display("FAIL b2b_gap: got restart %0d edges after done want 2", m); else pass_cnt++;
        total_cnt++; if (tx_b !== 1'b0) $display("FAIL b2b_start_bit: got %b want 0", tx_b); else pass_cnt++;
        start_b = 1'b0;
        wait_done_b(n2);
        total_cnt++; if (n2 != FRAME1) $display("FAIL b2b_len2: got %0d want %0d", n2, FRAME1); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (q_diff(q_b, exp) != 0) $display("FAIL b2b_bytes: got %0d bytes with %0d differences want 14 matching", q_b.size(), q_diff(q_b, exp)); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int offs [2] = '{83, 52};
        int dly  [2] = '{1, 3};
        for (int c = 0; c < 2; c++) begin
            data_b = 32'h12345678;
            kick_b();
            repeat (offs[c]) @(posedge clk);
            #(dly[c]);
            total_cnt++; if (tx_b !== 1'b0) $display("FAIL rst_pre_tx%0d: got %b want 0", c, tx_b); else pass_cnt++;
            rst = 1'b1;
            #1;
            total_cnt++; if (tx_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL rst_abort%0d: got tx=%b busy=%b want tx=1 busy=0", c, tx_b, busy_b); else pass_cnt++;
            total_cnt++; if (done_b !== 1'b0 || addr_b !== 5'd5) $display("FAIL rst_state%0d: got done=%b addr=%0d want done=0 addr=5", c, done_b, addr_b); else pass_cnt++;
            @(negedge clk); rst = 1'b0;
        end
        test_single();
    endtask

    task automatic test_hold_isolation();
        byte unsigned exp[$] = '{8'hA5, 8'h05, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h5A};
        int n;
        q_b.delete();
        data_b = 32'hCAFEF00D;
        kick_b();
        n = 0;
        while (done_b !== 1'b1 && n < LIMIT) begin
            @(posedge clk); #1; n++;
            if (n >= 44) data_b = $urandom;
        end
        total_cnt++; if (n != FRAME1) $display("FAIL hold_len: got %0d want %0d", n, FRAME1); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (q_diff(q_b, exp) != 0) $display("FAIL hold_bytes: got %0d bytes with %0d differences want 7 matching", q_b.size(), q_diff(q_b, exp)); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_start_ignored();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_hold_isolation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sm_regdump_tx.md
# sm_regdump_tx

Register-file dump engine for the debug read port of the single-cycle RISC-V core. On a start request it walks a configurable range of register addresses on `regAddr` and captures `regData` after a settle delay. Each captured word is streamed out as a UART 8N1 frame sequence on `tx`, so a host can read CPU state without the switch/LED readout path. It sits at the hardware top level on the fast board clock, beside the clock divider, and drives the CPU's `regAddr` input.

## Interface
- `BAUD_DIV`, 434: clock cycles per UART bit; legal range 2..65535, giving 115200 baud at 50 MHz.
- `SETTLE`, 3: wait cycles after `regAddr` changes before `regData` is sampled. This covers the top-level input filter plus the read path; legal range 1..255.
- `FIRST`, 0: first register address dumped, 0..31.
- `LAST`, 31: last register address dumped; `FIRST` ≤ `LAST` ≤ 31.

- `clk`  in  1  board clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  dump request; sampled only in IDLE.
- `regAddr`  out  5  register address presented to the CPU debug port.
- `regData`  in  32  register value returned by the CPU debug port.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high while a dump is in progress.
- `done`  out  1  one-cycle pulse at dump completion.

## Operation
- Frame format, bytes in order:
  - header 0xA5;
  - for each address a = FIRST..LAST: byte {3'b000, a}, then regData[31:24], [23:16], [15:8], [7:0];
  - trailer 0x5A.
- Byte serialiser:
  - start bit 0, then 8 data bits LSB first, then stop bit 1;
  - each bit is held exactly `BAUD_DIV` cycles, so one byte is 10·`BAUD_DIV` cycles;
  - the next byte's start bit begins on the cycle after the previous stop bit ends; there are no idle gaps inside a frame.
- FSM states: IDLE, HDR, SETTLE, CAPTURE, SEND, NEXT, TRL, DONE.
  - IDLE: `start`=1 → HDR.
  - HDR: serialise 0xA5, then → SETTLE with `regAddr`=`FIRST`.
  - SETTLE: count `SETTLE` cycles, then → CAPTURE.
  - CAPTURE: one cycle; latch `regData` into a 32-bit hold register; → SEND.
  - SEND: serialise the 5 bytes from the hold register, then → NEXT.
  - NEXT: if `regAddr` == `LAST` → TRL; otherwise `regAddr`+1 and → SETTLE. NEXT is zero-cycle, folded into the SEND exit.
  - TRL: serialise 0x5A, then → DONE.
  - DONE: one cycle; `done`=1; → IDLE.
- The hold register isolates the output: changes on `regData` during SEND do not affect transmitted bytes.
- `start` is ignored while `busy`=1. No queuing; a request made during a dump is lost.
- `start` held high across DONE re-triggers a new dump on the first IDLE cycle.
- `FIRST`==`LAST`: exactly one register record; the frame is 7 bytes.
- `regAddr` keeps its last value after DONE until the next dump loads `FIRST`.
- Counters:
  - baud counter is 16-bit, counts 0..`BAUD_DIV`−1;
  - bit index runs 0..9; byte index runs 0..4;
  - address increment is 5-bit and never wraps, because NEXT checks `LAST` first.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `regAddr`=`FIRST`; FSM in IDLE; all counters 0.
- Asserting `rst` mid-dump aborts immediately and asynchronously: `tx` goes to 1 and `busy` to 0. No trailer is sent; the host discards the truncated frame.
- Start latency: `start` sampled high at edge k → from edge k `busy`=1 and `tx`=0, the header start bit.
- Dump duration from edge k to the edge raising `done`: 10B + N·(`SETTLE`+1+50B) + 10B cycles, where B=`BAUD_DIV` and N=`LAST`−`FIRST`+1.
- `busy` falls on the same edge that raises `done`.
- `regAddr` is stable for at least `SETTLE` cycles before the capture edge and throughout CAPTURE.

## Test plan
- Full dump with B=4, `SETTLE`=2, `FIRST`=0, `LAST`=31, and a register model returning 0xDEAD0000|a:
  - UART monitor decodes A5, then for each a the bytes a, DE, AD, 00, a, then 5A;
  - `done` is asserted 6576 cycles after the start edge.
- Single-register dump with `FIRST`=`LAST`=5 and regData=0x12345678 → bytes A5 05 12 34 56 78 5A; frame length 70·B+`SETTLE`+1 cycles.
- Settle check: the register model applies a one-cycle pipeline delay and returns 0xFFFFFFFF for one cycle after each address change → captured data is correct and no 0xFF garbage appears in the stream.
- `start` pulsed every 100 cycles during a dump → exactly one frame is produced; `busy` stays high until `done`; `start` held high continuously → back-to-back frames separated by exactly one idle cycle.
- `rst` asserted mid-SEND at a bit boundary and again off-boundary → `tx`=1 and `busy`=0 within the same cycle. After release, a fresh `start` yields a complete, correct frame.
- `regData` toggled randomly during SEND → transmitted bytes equal the value latched at CAPTURE.
